if_fetch_stage: RTL and testbench

- Instruction-fetch stage directly upstream of the IF/ID pipeline register.
- Owns the program counter and issues word fetches to a request/grant instruction memory with in-order, variable-latency responses.
- Buffers returned words in a small FIFO and presents `instr`/`pc_plus4` to IF/ID; outputs NOP (32'h0) when empty.
- Handles hazard-unit stall and branch/jump redirect with discard of in-flight responses.

---
 rtl/if_fetch_stage.sv | 175 +++++++++++++++++
 tb/tb_if_fetch_stage.sv | 260 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/if_fetch_stage.sv
`default_nettype none
// =============================================================================
// Module   : if_fetch_stage
// Purpose  : Owns the fetch PC, issues word requests to a request/grant
//            instruction memory and buffers in-order responses for IF/ID.
//            Define IF_PERF_CNT_EN to add the pop/redirect perf counters.
// Revision : 1.0 - initial release
// =============================================================================
module if_fetch_stage #(
   parameter logic [31:0] RESET_PC   = 32'h0000_0000,
   parameter int          FIFO_DEPTH = 2,
   parameter int          OUT_W      = $clog2(FIFO_DEPTH) + 1
) (
   input  logic        clk,
   input  logic        rst,
   output logic        imem_req,
   output logic [31:0] imem_addr,
   input  logic        imem_gnt,
   input  logic        imem_rvalid,
   input  logic [31:0] imem_rdata,
   input  logic        stall,
   input  logic        redirect_valid,
   input  logic [31:0] redirect_pc,
   output logic [31:0] instr,
   output logic [31:0] pc_plus4,
   output logic        if_valid
`ifdef IF_PERF_CNT_EN
   ,
   output logic [31:0] perf_fetched,
   output logic [31:0] perf_redirects
`endif
);

   localparam int                 PTR_W     = $clog2(FIFO_DEPTH);
   localparam logic [OUT_W:0]     DEPTH_EXT = (OUT_W + 1)'(FIFO_DEPTH);
   localparam logic [OUT_W-1:0]   DEPTH_CNT = OUT_W'(FIFO_DEPTH);
   localparam logic [OUT_W-1:0]   CNT_ONE   = OUT_W'(1);
   localparam logic [PTR_W-1:0]   PTR_ONE   = PTR_W'(1);

   logic [31:0]      fetch_pc_q, fetch_pc_d;
   logic [31:0]      rsp_pc_q,   rsp_pc_d;
   logic [OUT_W-1:0] out_cnt_q,  out_cnt_d;
   logic [OUT_W-1:0] disc_cnt_q, disc_cnt_d;
   logic [OUT_W-1:0] count_q,    count_d;
   logic [PTR_W-1:0] wr_ptr_q,   wr_ptr_d;
   logic [PTR_W-1:0] rd_ptr_q,   rd_ptr_d;

   logic [31:0]      fifo_instr_q [FIFO_DEPTH];
   logic [31:0]      fifo_pc_q    [FIFO_DEPTH];

   logic             pop;
   logic             grant;
   logic             drop;
   logic             push;
   logic [31:0]      redir_tgt;
   logic [OUT_W:0]   credit_use;

   assign imem_addr = fetch_pc_q;
   assign if_valid  = (count_q != '0);
   assign instr     = if_valid ? fifo_instr_q[rd_ptr_q] : 32'h0;
   assign pc_plus4  = if_valid ? (fifo_pc_q[rd_ptr_q] + 32'd4) : 32'h0;

   // Credits cover words already buffered plus words still in flight, so a
   // response always finds a free slot.
   always_comb begin
      redir_tgt  = redirect_pc & 32'hFFFF_FFFC;
      pop        = if_valid & ~stall & ~redirect_valid;
      credit_use = {1'b0, out_cnt_q} + {1'b0, count_q} - (OUT_W + 1)'(pop);
      imem_req   = rst & ~redirect_valid & (credit_use < DEPTH_EXT);
      grant      = imem_req & imem_gnt;
      drop       = imem_rvalid & (disc_cnt_q != '0);
      push       = imem_rvalid & ~drop & ~redirect_valid;
   end

   always_comb begin
      fetch_pc_d = fetch_pc_q;
      rsp_pc_d   = rsp_pc_q;
      out_cnt_d  = out_cnt_q;
      disc_cnt_d = disc_cnt_q;
      count_d    = count_q;
      wr_ptr_d   = wr_ptr_q;
      rd_ptr_d   = rd_ptr_q;

      case ({grant, imem_rvalid})
         2'b10:   out_cnt_d = out_cnt_q + CNT_ONE;
         2'b01:   out_cnt_d = out_cnt_q - CNT_ONE;
         default: out_cnt_d = out_cnt_q;
      endcase

      if (grant) begin
         fetch_pc_d = fetch_pc_q + 32'd4;
      end
      if (drop) begin
         disc_cnt_d = disc_cnt_q - CNT_ONE;
      end
      if (push) begin
         rsp_pc_d = rsp_pc_q + 32'd4;
         wr_ptr_d = wr_ptr_q + PTR_ONE;
      end
      if (pop) begin
         rd_ptr_d = rd_ptr_q + PTR_ONE;
      end

      case ({push, pop})
         2'b10:   count_d = count_q + CNT_ONE;
         2'b01:   count_d = count_q - CNT_ONE;
         default: count_d = count_q;
      endcase

      // Every response still in flight after this edge belongs to the old
      // path; outstanding already includes words pending discard.
      if (redirect_valid) begin
         fetch_pc_d = redir_tgt;
         rsp_pc_d   = redir_tgt;
         count_d    = '0;
         wr_ptr_d   = '0;
         rd_ptr_d   = '0;
         disc_cnt_d = out_cnt_q - OUT_W'(imem_rvalid);
      end
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         fetch_pc_q <= RESET_PC;
         rsp_pc_q   <= RESET_PC;
         out_cnt_q  <= '0;
         disc_cnt_q <= '0;
         count_q    <= '0;
         wr_ptr_q   <= '0;
         rd_ptr_q   <= '0;
      end else begin
         fetch_pc_q <= fetch_pc_d;
         rsp_pc_q   <= rsp_pc_d;
         out_cnt_q  <= out_cnt_d;
         disc_cnt_q <= disc_cnt_d;
         count_q    <= count_d;
         wr_ptr_q   <= wr_ptr_d;
         rd_ptr_q   <= rd_ptr_d;
      end
   end

   always_ff @(posedge clk) begin
      if (push) begin
         fifo_instr_q[wr_ptr_q] <= imem_rdata;
         fifo_pc_q[wr_ptr_q]    <= rsp_pc_q;
      end
   end

   a_no_overflow : assert property (@(posedge clk) disable iff (!rst)
      !(push && !pop && (count_q == DEPTH_CNT)));

`ifdef IF_PERF_CNT_EN
   logic [31:0] perf_fetched_q;
   logic [31:0] perf_redirects_q;

   always_ff @(posedge clk) begin
      if (!rst) begin
         perf_fetched_q   <= 32'h0;
         perf_redirects_q <= 32'h0;
      end else begin
         if (pop) begin
            perf_fetched_q <= perf_fetched_q + 32'd1;
         end
         if (redirect_valid) begin
            perf_redirects_q <= perf_redirects_q + 32'd1;
         end
      end
   end

   assign perf_fetched   = perf_fetched_q;
   assign perf_redirects = perf_redirects_q;
`endif

endmodule
`default_nettype wire

// File: tb/tb_if_fetch_stage.sv
`default_nettype none
// =============================================================================
// Module   : tb_if_fetch_stage
// Purpose  : Randomized bench for if_fetch_stage against a queue-based model.
// Revision : 1.0 - initial release
// =============================================================================
module tb_if_fetch_stage;

   localparam int          FIFO_DEPTH = 2;
   localparam logic [31:0] RESET_PC   = 32'h0000_0000;
   localparam logic [31:0] DATA_OFS   = 32'h1000_0000;

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic        imem_req;
   logic [31:0] imem_addr;
   logic        imem_gnt = 1'b0;
   logic        imem_rvalid = 1'b0;
   logic [31:0] imem_rdata = 32'h0;
   logic        stall = 1'b0;
   logic        redirect_valid = 1'b0;
   logic [31:0] redirect_pc = 32'h0;
   logic [31:0] instr;
   logic [31:0] pc_plus4;
   logic        if_valid;
`ifdef IF_PERF_CNT_EN
   logic [31:0] perf_fetched;
   logic [31:0] perf_redirects;
`endif

   if_fetch_stage #(
      .RESET_PC   (RESET_PC),
      .FIFO_DEPTH (FIFO_DEPTH)
   ) u_dut (
      .clk            (clk),
      .rst            (rst),
      .imem_req       (imem_req),
      .imem_addr      (imem_addr),
      .imem_gnt       (imem_gnt),
      .imem_rvalid    (imem_rvalid),
      .imem_rdata     (imem_rdata),
      .stall          (stall),
      .redirect_valid (redirect_valid),
      .redirect_pc    (redirect_pc),
      .instr          (instr),
      .pc_plus4       (pc_plus4),
      .if_valid       (if_valid)
`ifdef IF_PERF_CNT_EN
      ,
      .perf_fetched   (perf_fetched),
      .perf_redirects (perf_redirects)
`endif
   );

   always #5 clk = ~clk;

   // In-flight request: address, earliest response cycle, wrong-path flag.
   typedef struct {
      logic [31:0] addr;
      int unsigned ready;
      bit          stale;
   } flight_t;

   typedef struct {
      logic [31:0] instr;
      logic [31:0] pc;
   } entry_t;

   flight_t     flight_q [$];
   entry_t      buf_q    [$];
   logic [31:0] model_pc;
   int unsigned cyc;
   int          lat_lo;
   int          lat_hi;
   int          pops_m;
   int          redirs_m;
   int          n_checks;
   int          n_fail;

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h (cycle %0d)", tag, got, exp, cyc);
      end
   endtask

   task automatic do_reset();
      @(negedge clk);
      rst            = 1'b0;
      stall          = 1'b0;
      redirect_valid = 1'b0;
      imem_gnt       = 1'b0;
      imem_rvalid    = 1'b0;
      repeat (2) @(posedge clk);
      @(negedge clk);
      #1;
      check_eq("rst_req",      imem_req,  32'h0);
      check_eq("rst_valid",    if_valid,  32'h0);
      check_eq("rst_instr",    instr,     32'h0);
      check_eq("rst_pc_plus4", pc_plus4,  32'h0);
      check_eq("rst_addr",     imem_addr, RESET_PC);
      flight_q.delete();
      buf_q.delete();
      model_pc = RESET_PC;
      pops_m   = 0;
      redirs_m = 0;
      rst      = 1'b1;
   endtask

   // One clock: drive inputs, compare against the model, then advance it.
   task automatic step(input bit s, input bit r, input logic [31:0] tgt,
                       input bit g, input bit rsp_ok);
      bit          rv;
      bit          exp_valid;
      bit          exp_req;
      bit          p;
      int          occ;
      flight_t     f;
      entry_t      e;
      logic [31:0] exp_instr;
      logic [31:0] exp_pc4;
      @(negedge clk);
      rv = rsp_ok && (flight_q.size() != 0);
      if (rv) rv = (flight_q[0].ready <= cyc);
      stall          = s;
      redirect_valid = r;
      redirect_pc    = tgt;
      imem_gnt       = g;
      imem_rvalid    = rv;
      imem_rdata     = rv ? (flight_q[0].addr + DATA_OFS) : $urandom;
      #1;
      exp_valid = (buf_q.size() != 0);
      exp_instr = 32'h0;
      exp_pc4   = 32'h0;
      if (exp_valid) begin
         exp_instr = buf_q[0].instr;
         exp_pc4   = buf_q[0].pc + 32'd4;
      end
      check_eq("if_valid",  if_valid,  exp_valid);
      check_eq("instr",     instr,     exp_instr);
      check_eq("pc_plus4",  pc_plus4,  exp_pc4);
      check_eq("imem_addr", imem_addr, model_pc);
      p       = exp_valid && !s && !r;
      occ     = flight_q.size() + buf_q.size() - int'(p);
      exp_req = !r && (occ < FIFO_DEPTH);
      check_eq("imem_req",  imem_req,  exp_req);

      if (p) begin
         void'(buf_q.pop_front());
         pops_m++;
      end
      if (rv) begin
         f = flight_q.pop_front();
         if (!f.stale && !r) begin
            e.instr = f.addr + DATA_OFS;
            e.pc    = f.addr;
            buf_q.push_back(e);
         end
      end
      if (exp_req && g) begin
         f.addr  = model_pc;
         f.ready = cyc + $urandom_range(lat_hi, lat_lo);
         f.stale = 1'b0;
         flight_q.push_back(f);
         model_pc = model_pc + 32'd4;
      end
      if (r) begin
         foreach (flight_q[i]) flight_q[i].stale = 1'b1;
         buf_q.delete();
         model_pc = tgt & 32'hFFFF_FFFC;
         redirs_m++;
      end
      cyc++;
   endtask

   initial begin
      n_checks = 0;
      n_fail   = 0;
      cyc      = 0;
      lat_lo   = 1;
      lat_hi   = 1;
      do_reset();

      // Single-cycle memory: start-up latency and the first few words.
      step(0, 0, 0, 1, 1);
      step(0, 0, 0, 1, 1);
      step(0, 0, 0, 1, 1);
      check_eq("first_instr", instr,    32'h1000_0000);
      check_eq("first_pc4",   pc_plus4, 32'h0000_0004);
      step(0, 0, 0, 1, 1);
      check_eq("second_instr", instr,    32'h1000_0004);
      check_eq("second_pc4",   pc_plus4, 32'h0000_0008);
      repeat (6) step(0, 0, 0, 1, 1);

      // Stall with the buffer full: requests stop, head frozen.
      repeat (5) step(1, 0, 0, 1, 1);
      check_eq("stall_req",   imem_req, 32'h0);
      check_eq("stall_valid", if_valid, 32'h1);
      repeat (6) step(0, 0, 0, 1, 1);

      // Redirect to an unaligned target with two words outstanding.
      lat_lo = 3;
      lat_hi = 3;
      repeat (4) step(0, 0, 0, 1, 1);
      step(0, 1, 32'h0000_0103, 1, 1);
      step(0, 0, 0, 0, 1);
      check_eq("redir_addr", imem_addr, 32'h0000_0100);
      repeat (10) step(0, 0, 0, 1, 1);

      // Redirect coinciding with a response and a stall.
      lat_lo = 1;
      lat_hi = 1;
      repeat (4) step(0, 0, 0, 1, 1);
      step(1, 1, 32'h0000_0200, 1, 1);
      step(0, 0, 0, 0, 1);
      check_eq("rr_valid", if_valid, 32'h0);
      check_eq("rr_instr", instr,    32'h0);

      // Grant withheld: request and address must hold.
      repeat (3) step(0, 0, 0, 0, 1);
      check_eq("hold_req",  imem_req,  32'h1);
      check_eq("hold_addr", imem_addr, 32'h0000_0200);
      repeat (4) step(0, 0, 0, 1, 1);

      // Address wrap at the top of the address space.
      step(0, 1, 32'hFFFF_FFFC, 1, 1);
      step(0, 0, 0, 1, 1);
      step(0, 0, 0, 1, 1);
      check_eq("wrap_addr", imem_addr, 32'h0000_0000);
      step(0, 0, 0, 1, 1);
      check_eq("wrap_pc4", pc_plus4, 32'h0000_0000);
      repeat (4) step(0, 0, 0, 1, 1);

      // Random traffic with variable latency, stalls and redirects.
      lat_lo = 1;
      lat_hi = 4;
      for (int i = 0; i < 2000; i++) begin
         step($urandom_range(99, 0) < 30, $urandom_range(99, 0) < 5, $urandom,
              $urandom_range(99, 0) < 70, $urandom_range(99, 0) < 80);
      end

      // Reset mid-operation, then more random traffic.
      do_reset();
      for (int i = 0; i < 600; i++) begin
         step($urandom_range(99, 0) < 25, $urandom_range(99, 0) < 4, $urandom,
              $urandom_range(99, 0) < 80, $urandom_range(99, 0) < 85);
      end

`ifdef IF_PERF_CNT_EN
      check_eq("perf_fetched",   perf_fetched,   pops_m);
      check_eq("perf_redirects", perf_redirects, redirs_m);
`endif

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
`default_nettype wire
